// File: rtl/alu16_sequencer_pkg.sv
// Shared types for the 16-bit arithmetic sequencer: ALU opcodes, sequencer ops
// and a nibble-carry helper used for the bit-11 half-carry of ADD HL,rr.
package alu16_sequencer_pkg;

   typedef enum logic [3:0] {
      alu_NOP = 4'd0,
      alu_ADD = 4'd1,
      alu_ADC = 4'd2,
      alu_SUB = 4'd3,
      alu_SBC = 4'd4
   } alu_op_t;

   typedef enum logic [1:0] {
      SEQ_ADD16 = 2'd0,
      SEQ_ADDSP = 2'd1,
      SEQ_INC16 = 2'd2,
      SEQ_DEC16 = 2'd3
   } seq_op_t;

   function automatic logic nib_carry(input logic [3:0] x, input logic [3:0] y, input logic cin);
      logic [4:0] sum;
      sum = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
      return sum[4];
   endfunction

endpackage

// File: rtl/alu16_sequencer.sv
// Drives the shared 8-bit ALU through a low-byte and a high-byte pass to build
// GameBoy 16-bit ADD/INC/DEC results together with the architectural flags.
module alu16_sequencer
   import alu16_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  seq_op_t     op,
   input  logic [15:0] opnd_a,
   input  logic [15:0] opnd_b,
   input  logic [3:0]  flags_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [3:0]  flags_out,
   output logic [7:0]  alu_op_A,
   output logic [7:0]  alu_op_B,
   output alu_op_t     alu_op_code,
   output logic [3:0]  alu_curr_flags,
   input  logic [7:0]  alu_result,
   input  logic [3:0]  alu_next_flags
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   seq_op_t     op_r;
   logic [15:0] a_r;
   logic [15:0] b_r;
   logic [3:0]  flags_r;
   logic [7:0]  res_lo_r;
   logic        c_lo_r;
   logic        h_lo_r;
   logic        busy_r;
   logic        done_r;

   // Z and N of the ALU are never consumed; only H and C matter here.
   logic        unused_alu_zn_s;
   assign unused_alu_zn_s = ^alu_next_flags[3:2];

   assign busy = busy_r;
   assign done = done_r;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    next_state_s = start ? LOW : IDLE;
         LOW:     next_state_s = HIGH;
         HIGH:    next_state_s = DONE;
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // ALU drive decoded from state and captured op; falls to NOP as soon as reset clears the state
   always_comb begin
      alu_op_code    = alu_NOP;
      alu_op_A       = 8'h00;
      alu_op_B       = 8'h00;
      alu_curr_flags = 4'b0000;
      case (state_r)
         LOW: begin
            alu_op_A = a_r[7:0];
            case (op_r)
               SEQ_ADD16, SEQ_ADDSP: begin alu_op_code = alu_ADD; alu_op_B = b_r[7:0]; end
               SEQ_INC16:            begin alu_op_code = alu_ADD; alu_op_B = 8'h01;    end
               SEQ_DEC16:            begin alu_op_code = alu_SUB; alu_op_B = 8'h01;    end
               default:              begin alu_op_code = alu_NOP; alu_op_A = 8'h00;    end
            endcase
         end
         HIGH: begin
            alu_op_A       = a_r[15:8];
            alu_curr_flags = {3'b000, c_lo_r};
            case (op_r)
               SEQ_ADD16: begin alu_op_code = alu_ADC; alu_op_B = b_r[15:8];   end
               SEQ_ADDSP: begin alu_op_code = alu_ADC; alu_op_B = {8{b_r[7]}}; end
               SEQ_INC16: begin alu_op_code = alu_ADC; alu_op_B = 8'h00;       end
               SEQ_DEC16: begin alu_op_code = alu_SBC; alu_op_B = 8'h00;       end
               default:   begin alu_op_code = alu_NOP; alu_op_A = 8'h00;       end
            endcase
         end
         default: begin
            alu_op_code = alu_NOP;
         end
      endcase
   end

   // Registered status outputs, aligned with the state they describe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (next_state_s != IDLE);
         done_r <= (next_state_s == DONE);
      end
   end

   // Operand capture, per-pass ALU sampling and final result/flag assembly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r      <= SEQ_ADD16;
         a_r       <= 16'h0000;
         b_r       <= 16'h0000;
         flags_r   <= 4'h0;
         res_lo_r  <= 8'h00;
         c_lo_r    <= 1'b0;
         h_lo_r    <= 1'b0;
         result    <= 16'h0000;
         flags_out <= 4'h0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  op_r    <= op;
                  a_r     <= opnd_a;
                  b_r     <= opnd_b;
                  flags_r <= flags_in;
               end
            end
            LOW: begin
               res_lo_r <= alu_result;
               c_lo_r   <= alu_next_flags[0];
               h_lo_r   <= alu_next_flags[1];
            end
            HIGH: begin
               // The low byte is committed together with the high byte so result stays stable between operations.
               case (op_r)
                  SEQ_ADD16: begin
                     result    <= {alu_result, res_lo_r};
                     flags_out <= {flags_r[3], 1'b0, nib_carry(a_r[11:8], b_r[11:8], c_lo_r), alu_next_flags[0]};
                  end
                  SEQ_ADDSP: begin
                     result    <= {alu_result, res_lo_r};
                     flags_out <= {2'b00, h_lo_r, c_lo_r};
                  end
                  SEQ_INC16, SEQ_DEC16: begin
                     result    <= {alu_result, res_lo_r};
                     flags_out <= flags_r;
                  end
                  default: begin
                     result    <= a_r;
                     flags_out <= flags_r;
                  end
               endcase
            end
            default: begin
               res_lo_r <= res_lo_r;
            end
         endcase
      end
   end

endmodule

// File: doc/alu16_sequencer.md
# alu16_sequencer

Multi-cycle 16-bit arithmetic sequencer that drives the 8-bit `alu` as an initiator. It splits the GameBoy 16-bit operations `ADD HL,rr`, `ADD SP,e`, `INC rr` and `DEC rr` into a low-byte pass and a high-byte pass through the shared ALU, chaining carry between them. It also assembles the architecturally correct F-register flags. It sits between the control FSM and the datapath, which muxes ALU ownership to this block while `busy` is high.

## Interface
Parameters: none.

**Timing and reset:** one clock; reset is asynchronous and active-high.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  `seq_op_t`  one of SEQ_ADD16, SEQ_ADDSP, SEQ_INC16, SEQ_DEC16
- `opnd_a`  in  16  first operand (HL, SP or rr)
- `opnd_b`  in  16  second operand (rr for ADD16; e in [7:0] for ADDSP, [15:8] ignored)
- `flags_in`  in  4  current flags {Z,N,H,C}
- `busy`  out  1  high from the cycle after accepted `start` through DONE
- `done`  out  1  one-cycle pulse; `result`/`flags_out` valid
- `result`  out  16  registered 16-bit result
- `flags_out`  out  4  registered new flags {Z,N,H,C}
- `alu_op_A`, `alu_op_B`  out  8  ALU operands
- `alu_op_code`  out  `alu_op_t`  ALU operation
- `alu_curr_flags`  out  4  ALU flags input
- `alu_result`  in  8  ALU result
- `alu_next_flags`  in  4  ALU flags output

## Operation
- **States:**
  - IDLE: `start`=1 → capture `op`, operands, `flags_in`; go to LOW.
  - LOW → HIGH unconditionally.
  - HIGH → DONE unconditionally.
  - DONE → IDLE unconditionally.
- **LOW pass:** `alu_curr_flags`=4'b0. Register `alu_result` into `result[7:0]` and `alu_next_flags[0]` into `c_lo`. Per op:
  - ADD16, ADDSP: `alu_ADD`, A=a[7:0], B=b[7:0].
  - INC16: `alu_ADD`, A=a[7:0], B=8'h01.
  - DEC16: `alu_SUB`, A=a[7:0], B=8'h01.
- **HIGH pass:** `alu_curr_flags`={3'b0,`c_lo`}. Register `alu_result` into `result[15:8]`. Per op:
  - ADD16: `alu_ADC`, A=a[15:8], B=b[15:8].
  - ADDSP: `alu_ADC`, A=a[15:8], B={8{b[7]}} (sign extension).
  - INC16: `alu_ADC`, A=a[15:8], B=8'h00.
  - DEC16: `alu_SBC`, A=a[15:8], B=8'h00.
- **Flags,** registered in HIGH:
  - ADD16: Z=flags_in.Z; N=0; H = carry out of bit 11, computed locally as ({1'b0,a[11:8]}+{1'b0,b[11:8]}+c_lo)[4] (ALU H is not used); C = `alu_next_flags[0]` of the HIGH pass.
  - ADDSP: Z=0, N=0, H and C taken from the LOW pass (low-nibble/low-byte unsigned add). Store the LOW-pass H in `h_lo`.
  - INC16, DEC16: flags_out=flags_in (no flag changes).
- **ALU idle drive:** in IDLE and DONE, `alu_op_code`=`alu_NOP`, operands 8'h00, `alu_curr_flags`=4'b0.
- **Width rules:** all arithmetic is modulo 2^16; wrap-around is silent apart from C.

## Timing
- **Reset:** state=IDLE, `busy`=0, `done`=0, `result`=16'h0000, `flags_out`=4'h0, `c_lo`=0, `h_lo`=0.
- **Latency:** with `start` sampled at edge N, LOW occupies cycle N+1, HIGH cycle N+2, and DONE cycle N+3 (`done`=1). The next `start` can be accepted at edge N+4.
- **busy:** `busy`=1 in LOW, HIGH and DONE.
- **Start while not IDLE:** ignored, with no queuing.
- **Operand stability:** operands may change after acceptance without effect.
- **Output hold:** `result`/`flags_out` hold their values after DONE until the next HIGH-state update.
- **ALU path:** purely combinational within a cycle; the ALU drive outputs are decoded from the state and the captured op.
- **Reset mid-operation:** immediate return to reset values. No `done` is produced, and the ALU drive falls to `alu_NOP` asynchronously.
- **Unknown `op` encoding at start:** accepted. The ALU is driven with `alu_NOP` in both passes, and at DONE `result`=opnd_a and flags_out=flags_in.

## Structure
- **Shared package:** add `seq_op_t` (2-bit enum: SEQ_ADD16, SEQ_ADDSP, SEQ_INC16, SEQ_DEC16) to `constants.sv`, alongside `alu_op_t`. Define the state enum locally.
- **Sub-modules:** none. The ALU stays external and shared; the datapath muxes it to this block while `busy`=1.

## Test plan
- ADD16, a=16'h0FFF, b=16'h0001, flags_in=4'b1000 → result 16'h1000, flags_out 4'b1010 (Z kept, H=1, C=0), `done` at N+3.
- ADD16, a=16'hFFFF, b=16'h0001, flags_in=4'b0000 → result 16'h0000, flags_out 4'b0011 (Z not set).
- ADDSP, a=16'hFFF8, b=16'h0008 → result 16'h0000, flags_out 4'b0011; then a=16'h1000, b=16'h00FE → result 16'h0FFE, flags_out 4'b0000.
- INC16 on 16'hFFFF and DEC16 on 16'h0000, flags_in=4'b0101 → results 16'h0000 and 16'hFFFF, flags_out 4'b0101 both times.
- `start` held high continuously → one operation every 4 cycles; a `start` pulsed during LOW/HIGH/DONE → no extra `done`.
- `rst` asserted during HIGH → `busy`=0, `done` never pulses, `result`=16'h0000, `alu_op_code`=`alu_NOP` in the same cycle.
